uart_tx_ctrl: RTL



---
 rtl/uart_tx_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: frame sequencer for the UART transmit path.
// It accepts one parallel word per Data_Valid handshake and serialises it onto
// TX_OUT as start bit, data bits LSB first, an optional parity bit and a stop bit.
// It owns the bit-period counter, the bit counter and the shift register.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous reset, active-low
//   P_DATA     parallel data word, latched on accept
//   Data_Valid request strobe, accepted only in IDLE
//   PAR_EN     parity bit enable, latched on accept
//   PAR_TYP    parity type for the parity calculator, latched on accept
//   parity_in  registered parity result from the parity calculator
//   TX_OUT     serial line, registered, idle high
//   Busy       frame in progress, registered
//   ser_en     high for the whole DATA state
//   mux_sel    bit source: 00 start, 01 data, 10 parity, 11 stop/idle
//   ser_done   pulse on the last clock of the last data bit
module uart_tx_ctrl #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             Data_Valid,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    input  logic             parity_in,
    output logic             TX_OUT,
    output logic             Busy,
    output logic             ser_en,
    output logic [1:0]       mux_sel,
    output logic             ser_done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    clk_cnt, clk_cnt_nxt;
    logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt, shifted;
    logic             par_en_q, par_en_nxt;
    logic             par_typ_q, par_typ_nxt;
    logic             tx_nxt, busy_nxt;
    logic             bit_end;

    // The parity type is consumed by the parity calculator; it is only held here.
    logic unused_par_typ;
    assign unused_par_typ = par_typ_q;

    assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign shifted = shreg >> 1;

    // TX_OUT is registered, so the next-state logic also computes the line value
    // that belongs to the state being entered.
    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = bit_end ? '0 : clk_cnt + CW'(1);
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        par_en_nxt  = par_en_q;
        par_typ_nxt = par_typ_q;
        tx_nxt      = TX_OUT;
        ser_en      = 1'b0;
        mux_sel     = 2'b11;
        ser_done    = 1'b0;

        case (state)
            IDLE: begin
                clk_cnt_nxt = '0;
                tx_nxt      = 1'b1;
                if (Data_Valid) begin
                    shreg_nxt   = P_DATA;
                    par_en_nxt  = PAR_EN;
                    par_typ_nxt = PAR_TYP;
                    state_nxt   = START;
                    tx_nxt      = 1'b0;
                end
            end
            START: begin
                mux_sel = 2'b00;
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                    tx_nxt      = shreg[0];
                end
            end
            DATA: begin
                mux_sel = 2'b01;
                ser_en  = 1'b1;
                if (bit_end) begin
                    shreg_nxt = shifted;
                    if (bit_cnt == BW'(WIDTH - 1)) begin
                        ser_done = 1'b1;
                        if (par_en_q) begin
                            state_nxt = PARITY;
                            tx_nxt    = parity_in;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                        tx_nxt      = shifted[0];
                    end
                end
            end
            PARITY: begin
                mux_sel = 2'b10;
                if (bit_end) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                mux_sel = 2'b11;
                if (bit_end) begin
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            clk_cnt   <= clk_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            par_en_q  <= par_en_nxt;
            par_typ_q <= par_typ_nxt;
            TX_OUT    <= tx_nxt;
            Busy      <= busy_nxt;
        end
    end

endmodule
